// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 Hz VGA raster timing generator with a registered pin stage.
//
// Ports:
//   CLOCK_25     in   25 MHz pixel clock, all logic on the rising edge
//   reset_n      in   synchronous active-low reset
//   color[2:0]   in   pixel colour for the current (x, y); [2]=R [1]=G [0]=B
//   test_pattern in   (only with VGA_TEST_PATTERN_EN) replace colour with 8 vertical bars
//   x[11:0]      out  1-based pixel column in the active region, 0 in blanking
//   y[11:0]      out  1-based pixel row in the active region, 0 in blanking
//   vga_r/g/b    out  registered colour pins, forced to 0 outside the active region
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   blank        out  high while the pins are outside the active region
//   frame_start  out  one-cycle pulse while the pins show pixel (1,1)
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds the test_pattern input).
//
// x/y are combinational from the counters (stage 0); every pin output is registered
// once from stage 0 so colour, syncs and blank share the same one-clock latency.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic        CLOCK_25,
    input  logic        reset_n,
    input  logic [2:0]  color,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] HActiveC    = 12'(H_ACTIVE);
    localparam logic [11:0] HSyncStartC = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HSyncEndC   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] HLastC      = 12'(H_TOTAL - 1);
    localparam logic [11:0] VActiveC    = 12'(V_ACTIVE);
    localparam logic [11:0] VSyncStartC = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VSyncEndC   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] VLastC      = 12'(V_TOTAL - 1);

    // Stage 0: raster counters
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    // Stage 1: pin registers
    logic [2:0]  rgb_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        blank_q;
    logic        frame_start_q;

    logic        active;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        first_pix;
    logic [2:0]  src_color;
    logic [2:0]  pix_color;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLastC) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLastC) ? '0 : v_cnt_q + 12'd1;
        end
    end

    assign active    = (h_cnt_q < HActiveC) && (v_cnt_q < VActiveC);
    assign hsync_raw = !((h_cnt_q >= HSyncStartC) && (h_cnt_q < HSyncEndC));
    assign vsync_raw = !((v_cnt_q >= VSyncStartC) && (v_cnt_q < VSyncEndC));
    assign first_pix = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

    assign x = active ? h_cnt_q + 12'd1 : 12'd0;
    assign y = active ? v_cnt_q + 12'd1 : 12'd0;

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars across the active line, colour index = bar number
    localparam logic [11:0] BarWidthC = 12'(H_ACTIVE / 8);
    logic [2:0] bar_sel;
    assign bar_sel = 3'(h_cnt_q / BarWidthC);
`endif

    always_comb begin
        src_color = color;
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern) begin
            src_color = bar_sel;
        end
`endif
        // Colour presented during blanking is dropped here, not at the pins
        pix_color = active ? src_color : 3'b000;
    end

    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= 3'b000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= pix_color;
            hsync_q       <= hsync_raw;
            vsync_q       <= vsync_raw;
            blank_q       <= !active;
            frame_start_q <= first_pix;
        end
    end

    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two instances share clock, reset and colour: one with the full 640x480 timing for
// line-level checks, one with a tiny raster so whole frames fit in a short run.
// A position-based reference model (cycles since reset, split with / and %) predicts
// x/y and the registered pins for both every cycle.

module tb_vga_timing_gen;

    localparam int SHA = 24, SHF = 3, SHS = 4, SHB = 5;
    localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHTOT  = SHA + SHF + SHS + SHB;
    localparam int SFRAME = SHTOT * (SVA + SVF + SVS + SVB);

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } timing_t;

    typedef struct packed {
        logic [2:0]  col;
        int          n;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } vec_t;

    logic        CLOCK_25 = 1'b0;
    logic        reset_n  = 1'b0;
    logic [2:0]  color    = 3'b000;
    logic        tp_val   = 1'b0;

    logic [11:0] d_x, d_y, s_x, s_y;
    logic        d_r, d_g, d_b, d_hs, d_vs, d_bl, d_fs;
    logic        s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs;
    logic [31:0] d_out, s_out;

    int          n_checks = 0;
    int          n_fail   = 0;

    timing_t     tm [2];
    int          pos [2];
    logic        prst [2];
    int          ppos [2];
    logic [2:0]  pcol [2];
    logic        known = 1'b0;

    vec_t        vt [12];

    always #20 CLOCK_25 = ~CLOCK_25;

    vga_timing_gen u_dflt (
        .CLOCK_25    (CLOCK_25),
        .reset_n     (reset_n),
        .color       (color),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(tp_val),
`endif
        .x           (d_x),
        .y           (d_y),
        .vga_r       (d_r),
        .vga_g       (d_g),
        .vga_b       (d_b),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .blank       (d_bl),
        .frame_start (d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_small (
        .CLOCK_25    (CLOCK_25),
        .reset_n     (reset_n),
        .color       (color),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(tp_val),
`endif
        .x           (s_x),
        .y           (s_y),
        .vga_r       (s_r),
        .vga_g       (s_g),
        .vga_b       (s_b),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .blank       (s_bl),
        .frame_start (s_fs)
    );

    assign d_out = {1'b0, d_x, d_y, d_r, d_g, d_b, d_hs, d_vs, d_bl, d_fs};
    assign s_out = {1'b0, s_x, s_y, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs};

    function automatic int htot(timing_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int ftot(timing_t t);
        return htot(t) * (t.va + t.vf + t.vs + t.vb);
    endfunction

    // Expected {x, y, r, g, b, hsync, vsync, blank, frame_start} from the current
    // raster position and the position/colour that was sampled one clock earlier.
    function automatic logic [31:0] model_out(timing_t t, int p, logic pr, int pp,
                                              logic [2:0] pc);
        int h, v, ph, pv;
        logic [11:0] ex, ey;
        logic [2:0]  rgb;
        logic        hs, vs, bl, fs;
        h  = p % htot(t);
        v  = p / htot(t);
        ex = 12'd0;
        ey = 12'd0;
        if (h < t.ha && v < t.va) begin
            ex = 12'(h + 1);
            ey = 12'(v + 1);
        end
        if (pr) begin
            rgb = 3'b000; hs = 1'b1; vs = 1'b1; bl = 1'b1; fs = 1'b0;
        end else begin
            ph  = pp % htot(t);
            pv  = pp / htot(t);
            bl  = !(ph < t.ha && pv < t.va);
            rgb = bl ? 3'b000 : pc;
            hs  = !(ph >= t.ha + t.hf && ph < t.ha + t.hf + t.hs);
            vs  = !(pv >= t.va + t.vf && pv < t.va + t.vf + t.vs);
            fs  = (pp == 0);
        end
        return {1'b0, ex, ey, rgb, hs, vs, bl, fs};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic       rn;
        logic [2:0] col;
        logic       tp;
        int         h;
        rn  = reset_n;
        col = color;
        tp  = tp_val;
        @(posedge CLOCK_25);
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                pos[i]  = 0;
                prst[i] = 1'b1;
            end else if (known) begin
                h       = pos[i] % htot(tm[i]);
                prst[i] = 1'b0;
                ppos[i] = pos[i];
                pcol[i] = tp ? 3'(h / (tm[i].ha / 8)) : col;
                pos[i]  = (pos[i] + 1) % ftot(tm[i]);
            end
        end
        if (!rn) known = 1'b1;
        #1;
        if (known) begin
            check("model_dflt", d_out, model_out(tm[0], pos[0], prst[0], ppos[0], pcol[0]));
            check("model_small", s_out, model_out(tm[1], pos[1], prst[1], ppos[1], pcol[1]));
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    initial begin
        int rgb_cnt, hs_low, first_low;
        int fs_seen, last_fs, vs_low, act_cnt, leak;

        tm[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
        tm[1] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB};
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; prst[i] = 1'b1; ppos[i] = 0; pcol[i] = 3'b000;
        end

        // {colour, clocks after release, x, y, rgb, hsync, vsync, blank, frame_start}
        vt[0]  = '{3'b101,    0, 12'd1, 12'd1, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{3'b101,    1, 12'd2, 12'd1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{3'b011,    2, 12'd3, 12'd1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{3'b110,  640, 12'd0, 12'd0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{3'b111,  641, 12'd0, 12'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{3'b111,  656, 12'd0, 12'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{3'b111,  657, 12'd0, 12'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{3'b111,  752, 12'd0, 12'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{3'b111,  753, 12'd0, 12'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{3'b111,  800, 12'd1, 12'd2, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{3'b010,  801, 12'd2, 12'd2, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{3'b111, 1441, 12'd0, 12'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};

        // Table vectors against the full-size instance, each from a fresh reset
        for (int k = 0; k < 12; k++) begin
            apply_reset(3);
            color = vt[k].col;
            repeat (vt[k].n) step();
            check($sformatf("vec%0d", k), d_out,
                  {1'b0, vt[k].ex, vt[k].ey, vt[k].rgb, vt[k].hs, vt[k].vs, vt[k].bl,
                   vt[k].fs});
        end

        // One full line with constant colour 101
        apply_reset(2);
        color     = 3'b101;
        rgb_cnt   = 0;
        hs_low    = 0;
        first_low = 0;
        for (int n = 1; n <= 800; n++) begin
            step();
            if ({d_r, d_g, d_b} == 3'b101) rgb_cnt++;
            if (!d_hs) begin
                hs_low++;
                if (first_low == 0) first_low = n;
            end
        end
        check("line_rgb_cycles", rgb_cnt, 640);
        check("line_hsync_width", hs_low, 96);
        check("line_hsync_start", first_low, 657);

        // Whole frames on the small instance with colour held at 111
        apply_reset(2);
        color   = 3'b111;
        fs_seen = 0;
        last_fs = 0;
        vs_low  = 0;
        act_cnt = 0;
        leak    = 0;
        for (int n = 1; n <= 4 * SFRAME + 20 && fs_seen < 4; n++) begin
            step();
            if (s_fs) begin
                if (fs_seen > 0) check("frame_interval", n - last_fs, SFRAME);
                fs_seen++;
                last_fs = n;
            end
            if (fs_seen >= 1 && fs_seen < 4) begin
                if (!s_vs) vs_low++;
                if (!s_bl) act_cnt++;
            end
            if (s_bl && {s_r, s_g, s_b} != 3'b000) leak++;
            if (d_bl && {d_r, d_g, d_b} != 3'b000) leak++;
        end
        check("frame_start_count", fs_seen, 4);
        check("frame_vsync_low", vs_low, 3 * SVS * SHTOT);
        check("frame_active_cycles", act_cnt, 3 * SHA * SVA);
        check("blank_colour_leak", leak, 0);

        // Reset mid-frame at x=300, y=2 on the full-size instance
        apply_reset(1);
        color = 3'b111;
        repeat (1099) step();
        check("mid_pos", 32'({d_x, d_y}), 32'({12'd300, 12'd2}));
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_pins_dflt", 32'({d_r, d_g, d_b, d_hs, d_vs, d_bl, d_fs}),
                  32'(7'b0001110));
            check("mid_rst_pins_small", 32'({s_r, s_g, s_b, s_hs, s_vs, s_bl, s_fs}),
                  32'(7'b0001110));
        end
        reset_n = 1'b1;
        check("mid_release_xy", 32'({d_x, d_y, s_x, s_y}), 32'({12'd1, 12'd1, 12'd1, 12'd1}));
        step();
        check("mid_release_fs", 32'({d_fs, d_bl, s_fs, s_bl}), 32'(4'b1010));

`ifdef VGA_TEST_PATTERN_EN
        apply_reset(1);
        tp_val = 1'b1;
        color  = 3'b000;
        for (int n = 1; n <= 800; n++) begin
            step();
            if (n <= 640) check("bar_colour", 32'({d_r, d_g, d_b}), 32'((n - 1) / 80));
        end
        tp_val = 1'b0;
`endif

        // Random colour, occasional resets of 1..3 clocks, checked by the model
        for (int n = 0; n < 20000; n++) begin
            color = 3'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                reset_n = 1'b1;
            end
`ifdef VGA_TEST_PATTERN_EN
            if ($urandom_range(0, 299) == 0) tp_val = ~tp_val;
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces 640x480@60 Hz VGA raster timing from CLOCK_25 and drives the pixel coordinate bus (x, y) consumed by the image generator.
- Samples the returned 3-bit colour and outputs registered, sync-aligned R/G/B, hsync and vsync to the DAC/connector pins.
- Sits at the top level between the image generator and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- CLOCK_25  in  1  25 MHz pixel clock; all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- color  in  3  pixel colour from the image generator for the current (x, y); [2]=R, [1]=G, [0]=B
- x  out  12  1-based pixel column, 1..640 in active region, 0 in blanking
- y  out  12  1-based pixel row, 1..480 in active region, 0 in blanking
- vga_r  out  1  red pin
- vga_g  out  1  green pin
- vga_b  out  1  blue pin
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high when the pin outputs are outside the active region
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of each frame on the pins

Behaviour:
- Clock and reset: one clock, CLOCK_25. Reset is synchronous and active-low on reset_n.
- Horizontal counter h_cnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters = 800.
- Vertical counter v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 525. v_cnt increments when h_cnt wraps 799->0.
- Both counters wrap to 0 together at (799, 524).
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- x and y are combinational from the counters:
  - In the active region, x = h_cnt+1 and y = v_cnt+1.
  - Otherwise x = 0 and y = 0.
  - Both are zero-extended to 12 bits. x never exceeds 640 and y never exceeds 480.
- Stage 0 sync raw values:
  - hsync_raw = 0 iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync_raw = 0 iff V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491.
- Pipeline: colour is sampled in the same cycle x/y are presented. vga_r/g/b, hsync, vsync, blank and frame_start are all registered once. Latency from counter value to pin outputs is exactly 1 clock, so pins and syncs stay mutually aligned.
- Colour gating: vga_r/g/b = color bits when the stage 0 region was active, else 0. Colour received outside the active region is ignored.
- frame_start = 1 for the single cycle in which the pins show pixel (1,1).
- Reset (reset_n=0 at a clock edge):
  - h_cnt = 0 and v_cnt = 0.
  - vga_r/g/b = 0, hsync = 1, vsync = 1, blank = 1, frame_start = 0.
  - During reset, x = 1 and y = 1 (counters held at 0).
- Reset mid-frame abandons the current frame. The first clock after release presents pixel (1,1) on x/y, and frame_start pulses one clock later.
- No other inputs affect timing. The counter sequence is free-running and fully deterministic.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds input test_pattern (1 bit). When it is high, the stage 0 colour is replaced by eight vertical bars of 80 px each. The bar colour value is (h_cnt/80) as 3 bits, left to right 000..111. Timing is unchanged and the color input is ignored.
- Not defined: the port is absent and colour always comes from the color input.

Test Plan:
- Reset then release: during reset, x=1, y=1, hsync=1, vsync=1, blank=1, RGB=000. One clock after release, blank=0, frame_start=1, and RGB equals the colour driven for (1,1).
- Hold color=3'b101 for a full line: x counts 1..640 with y=1, then 0 for 160 clocks. vga_r=1, vga_g=0, vga_b=1 for exactly 640 clocks. hsync is low for exactly 96 clocks, starting 17 clocks after the last active pixel leaves the pins.
- Run a full frame: frame_start is spaced 420000 clocks apart. vsync is low for 1600 clocks, starting at the line where v_cnt=490. Exactly 480 lines show blank=0.
- Drive color=3'b111 constantly: RGB=000 whenever blank=1, including front/back porch. No pixel appears at x>640 or y>480.
- Assert reset_n=0 for 3 clocks at x=300, y=200, then release: outputs hold their reset values during reset. The next frame restarts at (1,1) with frame_start one clock after release.
- With VGA_TEST_PATTERN_EN defined and test_pattern=1, color=3'b000: pin colour equals 000 for x 1..80, 001 for x 81..160, and so on, with 111 for x 561..640. Sync timing is identical to the tests above.
